// File: rtl/mc_nport.sv
// N-port byte-serial memory controller: arbitrates 1..MAX_LEN byte requests onto one 8-bit RAM bus.
// Optional macro MC_RR_ARB_EN selects round-robin arbitration; otherwise fixed priority (highest index wins).
module mc_nport #(
  parameter int NPORT   = 2,
  parameter int MAX_LEN = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic [NPORT-1:0]           re,
  input  logic [NPORT-1:0]           we,
  input  logic [NPORT*32-1:0]        addr,
  input  logic [NPORT*8*MAX_LEN-1:0] w_data,
  input  logic [NPORT*3-1:0]         len_in_byte,
  output logic [NPORT*8*MAX_LEN-1:0] r_data,
  output logic [NPORT-1:0]           state_busy,
  output logic [NPORT-1:0]           state_done,
  output logic [31:0]                mem_a,
  output logic [7:0]                 mem_dout,
  input  logic [7:0]                 mem_din,
  output logic                       mem_wr
);
  localparam int DW = 8 * MAX_LEN;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int KW = 4;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     g_q, g_d;
  logic              op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [DW-1:0]     wdat_q, wdat_d;
  logic [KW-1:0]     len_q, len_d;
  logic [KW-1:0]     k_q, k_d;
  logic              pend_q, pend_d;
  logic [KW-1:0]     pidx_q, pidx_d;
  logic [DW-1:0]     buf_q, buf_d;
  logic [NPORT*DW-1:0] rdat_q, rdat_d;
  logic [NPORT-1:0]  busy_q, busy_d;
  logic [NPORT-1:0]  done_q, done_d;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;

  logic [NPORT-1:0]  req;
  logic              gnt_v;
  logic [PW-1:0]     gnt;
  logic [2:0]        gl;
  logic [KW-1:0]     gl_eff;

  assign req = re | we;

`ifdef MC_RR_ARB_EN
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int j;
    gnt_v = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int i = 1; i <= NPORT; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NPORT) j = j - NPORT;
      if (!gnt_v && req[j]) begin
        gnt_v = 1'b1;
        gnt   = PW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (rdy_in && state_q == IDLE && gnt_v) ptr_d = gnt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ptr_q <= PW'(NPORT - 1);
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (req[i]) begin
        gnt_v = 1'b1;
        gnt   = PW'(i);
      end
    end
  end
`endif

  // Out-of-range lengths (0, or above MAX_LEN) become full-width transfers.
  assign gl     = len_in_byte[int'(gnt)*3 +: 3];
  assign gl_eff = (gl == 3'd0 || int'(gl) > MAX_LEN) ? KW'(MAX_LEN) : {1'b0, gl};

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    len_d      = len_q;
    k_d        = k_q;
    pend_d     = 1'b0;
    pidx_d     = pidx_q;
    buf_d      = buf_q;
    rdat_d     = rdat_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;

    // Read capture runs even while stalled so the in-flight byte is never dropped.
    for (int b = 0; b < MAX_LEN; b++) begin
      if (pend_q && int'(pidx_q) == b) buf_d[b*8 +: 8] = mem_din;
    end

    if (rdy_in) begin
      done_d = '0;
      case (state_q)
        IDLE: begin
          if (gnt_v) begin
            state_d     = XFER;
            g_d         = gnt;
            op_d        = we[gnt];
            addr_d      = addr[int'(gnt)*32 +: 32];
            wdat_d      = w_data[int'(gnt)*DW +: DW];
            len_d       = gl_eff;
            k_d         = '0;
            busy_d      = '0;
            busy_d[gnt] = 1'b1;
            mem_a_d     = addr[int'(gnt)*32 +: 32];
            mem_dout_d  = w_data[int'(gnt)*DW +: 8];
          end
        end
        XFER: begin
          if (op_q) begin
            k_d     = k_q + 1'b1;
            mem_a_d = addr_q + 32'(k_q) + 32'd1;
            for (int b = 0; b < MAX_LEN; b++) begin
              if (int'(k_q) + 1 == b) mem_dout_d = wdat_q[b*8 +: 8];
            end
            if (k_q == len_q - 1'b1) begin
              state_d     = DONE;
              busy_d      = '0;
              done_d[g_q] = 1'b1;
            end
          end else if (k_q < len_q) begin
            pend_d  = 1'b1;
            pidx_d  = k_q;
            k_d     = k_q + 1'b1;
            mem_a_d = addr_q + 32'(k_q) + 32'd1;
          end else begin
            state_d     = DONE;
            busy_d      = '0;
            done_d[g_q] = 1'b1;
            for (int p = 0; p < NPORT; p++) begin
              if (int'(g_q) == p) begin
                for (int b = 0; b < MAX_LEN; b++) begin
                  rdat_d[p*DW + b*8 +: 8] = (b < int'(len_q)) ? buf_d[b*8 +: 8] : 8'h00;
                end
              end
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      g_q        <= '0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      len_q      <= '0;
      k_q        <= '0;
      pend_q     <= 1'b0;
      pidx_q     <= '0;
      buf_q      <= '0;
      rdat_q     <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      len_q      <= len_d;
      k_q        <= k_d;
      pend_q     <= pend_d;
      pidx_q     <= pidx_d;
      buf_q      <= buf_d;
      rdat_q     <= rdat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
    end
  end

  // Write strobe is decoded from state so reset or a stall kills it in the same cycle.
  assign mem_wr     = (state_q == XFER) && op_q && rdy_in;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign r_data     = rdat_q;
  assign state_busy = busy_q;
  assign state_done = done_q;

endmodule

// File: doc/mc_nport.md
# mc_nport

N-port, byte-serial memory controller arbitrating 1–4-byte read/write requests from pipeline stages onto the single 8-bit RAM bus. Generalises the two-port controller to `NPORT` channels with a configurable arbitration mode. Adds stall-safe read capture under `rdy_in` and zero-filled partial reads. Sits between the CPU stages (IF = port 0, MEM = port 1, spare ports for future cache/DMA) and the `mem_*` pins of `cpu`.

## Interface
- `NPORT`, 2, number of requester ports (2..8)
- `MAX_LEN`, 4, maximum transfer length in bytes; port data width is `8*MAX_LEN`
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset; asynchronous, active-high
- `rdy_in`  in  1  pause when low
- `re`  in  NPORT  per-port read request, held until `done`
- `we`  in  NPORT  per-port write request, held until `done`
- `addr`  in  NPORT*32  per-port byte address, slice i = port i
- `w_data`  in  NPORT*8*MAX_LEN  per-port write data, byte 0 = LSB, written to `addr`
- `len_in_byte`  in  NPORT*3  per-port length; 1..MAX_LEN legal, anything else treated as MAX_LEN
- `r_data`  out  NPORT*8*MAX_LEN  per-port read result, held until that port's next completion
- `state_busy`  out  NPORT  port's transaction accepted and in progress
- `state_done`  out  NPORT  one-cycle completion pulse
- `mem_a`  out  32  RAM address
- `mem_dout`  out  8  RAM write byte
- `mem_din`  in  8  RAM read byte; valid the cycle after its address
- `mem_wr`  out  1  1 = write

## Operation
- Reset values: all `r_data`, `state_busy`, `state_done` 0; `mem_a` 0, `mem_dout` 0, `mem_wr` 0; FSM IDLE; RR pointer NPORT-1.
- `mem_wr` decodes combinationally from state registers, so it is 0 immediately on reset assertion, including mid-write.
- States: IDLE, XFER, DONE.
- IDLE: if any `re|we`, grant one port `g` per arbitration and latch `addr`, `w_data`, len and op; `k`=0; go to XFER. Same-port `re` and `we` together: write wins.
- XFER write: drive `mem_a`=addr+k, `mem_dout`=byte k, `mem_wr`=1; `k`++. After k=len-1, go to DONE.
- XFER read: for k<len, drive `mem_a`=addr+k, `mem_wr`=0, and set pending tag (`pend`=1, `pend_idx`=k). Stay until k=len, an issue-free capture cycle, then go to DONE.
- Capture: any cycle with `pend`=1 writes `mem_din` to buffer byte `pend_idx` and clears `pend`. This is not gated by `rdy_in`.
- DONE: `state_done[g]`=1 for one cycle. `r_data[g]` is updated with the buffer, bytes ≥ len zero-filled (no sign extension). `state_busy[g]` drops. Go to IDLE.
- `state_busy[g]`=1 from XFER entry through the last XFER cycle; other ports stay 0.
- Requests arriving during XFER/DONE wait. The requester deasserts at the edge it sees `done`, so IDLE never re-grants a finished request.
- Address arithmetic is 32-bit, wrapping at 2^32.

## Timing
- Request sampled in IDLE cycle 0.
- Write of L bytes: bytes on the bus cycles 1..L, `done` cycle L+1.
- Read of L bytes: addresses cycles 1..L, capture cycles 2..L+1, `done` cycle L+2.
- Back-to-back: a new grant is possible in the IDLE cycle after DONE, so the minimum gap is 1 idle cycle.
- `rdy_in` low: FSM, `k`, latched request and outputs freeze (except the capture above) and `mem_wr` is forced 0. On resume, address k is issued; no byte is lost or duplicated.
- `rst_in` mid-transaction: transaction is abandoned; no `done` pulse; `r_data` cleared.

## Configuration
- `MC_RR_ARB_EN` defined: round-robin arbitration. Search starts at pointer+1 mod NPORT; the pointer updates to `g` on each grant.
- `MC_RR_ARB_EN` undefined: fixed priority, highest index wins (MEM over IF); no pointer register.

## Test plan
- Write, port 1: `addr`=0x100, `w_data`=0xDDCCBBAA, len 4 → bus writes AA,BB,CC,DD to 0x100..0x103 in cycles 1–4; `done[1]` cycle 5.
- Read, port 0: addr 0x100, len 4, RAM model as above → `r_data[0]`=0xDDCCBBAA, `done[0]` at cycle 6. Repeat with len 1 → 0x000000AA, `done` cycle 3.
- Simultaneous `re[0]`, `re[1]` continuously: without macro, port 1 is always granted first. With `MC_RR_ARB_EN`, grants alternate 0,1,0,1 starting at 0.
- `rdy_in` low for 3 cycles mid 4-byte read at k=2 → result still 0xDDCCBBAA; no `mem_wr` pulses; `done` delayed exactly 3 cycles.
- `rst_in` pulse during byte 2 of a write → `mem_wr`=0 same cycle, byte 3 never written, no `done`; FSM IDLE.
- len 0 on port 1 read → treated as 4-byte read.
